if_fetch_unit: RTL
==================

# if_fetch_unit

Instruction-fetch stage controller for the pipelined RISC-V core. It owns the program counter and issues one request at a time to instruction memory over a valid/ready request channel with a valid-only response. It consumes the sequential next address (PC+4) and branch/jump redirects, and drives the IF/ID pipeline register. It honours the hazard unit's stall and flushes on redirect.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- NOP_INSTR, 32'h0000_0013, instruction word placed in IF/ID on reset/flush (addi x0,x0,0)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- redirect_valid  in  1  taken branch/jump from EX this cycle
- redirect_pc  in  32  redirect target; bits [1:0] ignored (treated as 0)
- stall  in  1  hazard unit holds IF/ID and PC
- imem_req_valid  out  1  fetch request valid
- imem_req_addr  out  32  fetch address (always the current PC)
- imem_req_ready  in  1  memory accepts request
- imem_rsp_valid  in  1  response data valid (one per accepted request, never in the acceptance cycle)
- imem_rsp_data  in  32  instruction word
- ifid_valid  out  1  IF/ID holds a live instruction
- ifid_pc  out  32  PC of the IF/ID instruction
- ifid_pc_plus4  out  32  ifid_pc + 4
- ifid_instr  out  32  instruction word

## Operation
- Registers: pc, state, skid_instr (32), IF/ID fields.
- States: IDLE, FETCH, WAIT, HOLD, DROP. At most one request outstanding.
- imem_req_valid = (state==FETCH) && !redirect_valid; imem_req_addr = pc.
- IDLE: go to FETCH unconditionally.
- FETCH: on handshake (valid && ready) go to WAIT; else stay.
- WAIT, rsp_valid && !stall: load IF/ID {1, pc, pc+4, rsp_data}; pc <= pc+4; go to FETCH.
- WAIT, rsp_valid && stall: skid_instr <= rsp_data; go to HOLD; PC and IF/ID unchanged.
- WAIT, no rsp: stay.
- HOLD, !stall: load IF/ID from skid_instr with pc/pc+4; pc <= pc+4; go to FETCH. With stall, stay.
- DROP: waits for the stale response and discards it on rsp_valid, then goes to FETCH.
- IF/ID when not loaded: if stall, hold all fields; else ifid_valid <= 0 (bubble); other fields hold.
- Redirect has priority over stall and over everything else:
  - pc <= {redirect_pc[31:2],2'b00}.
  - ifid_valid <= 0 and ifid_instr <= NOP_INSTR.
  - FETCH: no request issued this cycle; stay in FETCH.
  - WAIT without rsp: go to DROP.
  - WAIT with rsp: discard it; go to FETCH.
  - HOLD: discard skid; go to FETCH.
  - DROP: go to DROP (or to FETCH if rsp arrives the same cycle).
  - IDLE: go to FETCH.
- Arithmetic: pc+4 is modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).

## Timing
- Reset values: state=IDLE, pc=RESET_PC, ifid_valid=0, ifid_pc=0, ifid_pc_plus4=0, ifid_instr=NOP_INSTR, skid_instr=0; imem_req_valid=0.
- First request: the first cycle after rst deasserts is IDLE; imem_req_valid=1 on the second.
- Latency: an instruction appears in IF/ID on the edge that samples imem_rsp_valid. Peak throughput is one instruction per 2 cycles (FETCH, WAIT) with 1-cycle memory.
- The redirect target is requested in the cycle after redirect_valid (FETCH case), or after the stale response drains (DROP).
- rst mid-transaction: all state returns to reset values immediately; the outstanding response after reset is the memory's responsibility (memory shares rst).

## Test plan
- Reset then free-run, ready=1, rsp one cycle after accept: requests 0x0,0x4,0x8 every 2 cycles; ifid_pc=0x0,0x4,0x8 with ifid_pc_plus4=0x4,0x8,0xC, ifid_valid pulsing.
- Stall asserted when rsp for 0x4 arrives, held 3 cycles: IF/ID keeps 0x0 instr; on release IF/ID=0x4 with skid data, next request 0x8.
- Redirect to 0x100 while WAIT on 0x8: ifid_valid=0 next cycle; response for 0x8 discarded; next request addr=0x100; ifid_pc=0x100 afterwards.
- Redirect and stall together in HOLD, redirect_pc=0x203: skid discarded, IF/ID flushed to NOP_INSTR, next request addr=0x200.
- imem_req_ready low 4 cycles in FETCH: imem_req_valid stays 1 with a stable addr; no IF/ID load; ifid_valid=0 after the first bubble.
- pc=0xFFFF_FFFC fetched: ifid_pc_plus4=0x0 and the next request addr=0x0. Asserting rst mid-WAIT returns pc to RESET_PC and ifid_valid to 0 asynchronously.

Source files
------------

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory port of the fetch stage. The request side is a valid/ready
// channel. The response side is valid-only and returns one word per accepted request.
interface if_fetch_unit_if;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;

    // The fetch unit issues requests and consumes responses.
    modport master (
        output req_valid,
        output req_addr,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data
    );

    // The instruction memory accepts requests and produces responses.
    modport slave (
        input  req_valid,
        input  req_addr,
        output req_ready,
        output rsp_valid,
        output rsp_data
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage controller. It owns the PC and keeps at most one
// instruction-memory request outstanding. It feeds the IF/ID register, honours the
// hazard-unit stall, and flushes on a branch/jump redirect from EX.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    input  logic              stall,
    if_fetch_unit_if.master   imem,
    output logic              ifid_valid,
    output logic [31:0]       ifid_pc,
    output logic [31:0]       ifid_pc_plus4,
    output logic [31:0]       ifid_instr
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        HOLD,
        DROP
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] skid_instr;
    logic [31:0] redirect_target;

    // The PC wraps modulo 2^32. Redirect targets are forced to word alignment.
    assign pc_plus4        = pc + 32'd4;
    assign redirect_target = redirect_pc & ~32'h0000_0003;

    // A request is only offered from FETCH. A redirect in the same cycle suppresses it,
    // so the stale PC is never sent to memory.
    assign imem.req_valid = (state == FETCH) && !redirect_valid;
    assign imem.req_addr  = pc;

    // PC, FSM, skid buffer and IF/ID register. A redirect overrides everything else.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            pc            <= RESET_PC;
            ifid_valid    <= 1'b0;
            ifid_pc       <= 32'h0000_0000;
            ifid_pc_plus4 <= 32'h0000_0000;
            ifid_instr    <= NOP_INSTR;
            skid_instr    <= 32'h0000_0000;
        end else if (redirect_valid) begin
            pc         <= redirect_target;
            ifid_valid <= 1'b0;
            ifid_instr <= NOP_INSTR;
            case (state)
                WAIT:    state <= imem.rsp_valid ? FETCH : DROP;
                DROP:    state <= imem.rsp_valid ? FETCH : DROP;
                default: state <= FETCH;
            endcase
        end else begin
            if (!stall) begin
                ifid_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    state <= FETCH;
                end
                FETCH: begin
                    if (imem.req_valid && imem.req_ready) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem.rsp_valid) begin
                        if (stall) begin
                            skid_instr <= imem.rsp_data;
                            state      <= HOLD;
                        end else begin
                            ifid_valid    <= 1'b1;
                            ifid_pc       <= pc;
                            ifid_pc_plus4 <= pc_plus4;
                            ifid_instr    <= imem.rsp_data;
                            pc            <= pc_plus4;
                            state         <= FETCH;
                        end
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        ifid_valid    <= 1'b1;
                        ifid_pc       <= pc;
                        ifid_pc_plus4 <= pc_plus4;
                        ifid_instr    <= skid_instr;
                        pc            <= pc_plus4;
                        state         <= FETCH;
                    end
                end
                DROP: begin
                    if (imem.rsp_valid) begin
                        state <= FETCH;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
